// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path.
//  GLYPH     : active-high gfedcba patterns for hex digits 0..F
//  SEG_BLANK : active-high pattern for a dark digit
//  cnt_width : bit width needed to hold values 0..n-1 (never less than 1)
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic int cnt_width(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational hex-to-glyph lookup.
//  nibble : hex digit to display
//  blank  : 1 forces all segments off
//  glyph  : active-high segments, bit6=g .. bit0=a
module seven_segment_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH[nibble];
      if (blank) glyph = SEG_BLANK;
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment scanner.
//  clk, rst_n   : clock, asynchronous active-low reset
//  enable       : 0 darkens the display and freezes the scan
//  value, dp    : packed nibbles (digit 0 in [3:0]) and per-digit decimal points
//  blank_lz     : suppress leading zeros
//  bright       : on-time level, 7 = full slot, 0 = shortest
//  seg, dp_out  : segment and decimal point pins
//  an           : digit select pins, one-hot when lit
//  frame_start  : one-cycle pulse when the shadow registers load
// All outputs are registered. They are computed from the next-cycle state so that
// an/seg line up with the prescaler/digit they describe.
module seven_segment_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter bit SEG_ACTIVE_LOW   = 1'b1,
   parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    blank_lz,
   input  logic [2:0]              bright,
   output logic [6:0]              seg,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int PW = cnt_width(REFRESH_DIV);
   localparam int IW = cnt_width(NUM_DIGITS);
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic DP_OFF = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = DIGIT_ACTIVE_LOW ? '1 : '0;

   logic [PW-1:0]           pre_q, pre_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sval_q, sval_d;
   logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
   logic                    sblz_q, sblz_d;
   logic                    primed_q;
   logic                    load;

   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [NUM_DIGITS-1:0]   sel;
   logic [3:0]              nib;
   logic                    blank_this;
   logic                    dp_this;
   logic                    upper_zero;
   logic                    lit;
   logic [31:0]             on_cycles;
   logic [6:0]              glyph;
   logic [6:0]              seg_d;
   logic                    dp_pin_d;
   logic [NUM_DIGITS-1:0]   an_d;

   // Scan counters and shadow load. The very first enabled cycle after reset only
   // loads the shadows and keeps the prescaler at 0, so that frame opens with a
   // dead-time cycle just like every later frame.
   always_comb begin
      pre_d = pre_q;
      idx_d = idx_q;
      load  = 1'b0;
      if (enable) begin
         if (!primed_q) begin
            load = 1'b1;
         end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               load  = 1'b1;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
      sval_d = load ? value    : sval_q;
      sdp_d  = load ? dp       : sdp_q;
      sblz_d = load ? blank_lz : sblz_q;
   end

   // Digit k is blanked when every nibble from k upward is zero; digit 0 always shows.
   always_comb begin
      upper_zero = 1'b1;
      blank_mask = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero    = upper_zero & (sval_d[4*k +: 4] == 4'h0);
         blank_mask[k] = sblz_d & upper_zero & (k != 0);
      end
   end

   always_comb begin
      nib        = 4'h0;
      blank_this = 1'b0;
      dp_this    = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_d == IW'(k)) begin
            nib        = sval_d[4*k +: 4];
            blank_this = blank_mask[k];
            dp_this    = sdp_d[k];
         end
      end
   end

   seven_segment_decoder u_dec (
      .nibble (nib),
      .blank  (blank_this),
      .glyph  (glyph)
   );

   // Prescaler 0 is always dead time; the lit window ends before on_cycles.
   always_comb begin
      on_cycles = ((32'(bright) + 32'd1) * 32'(REFRESH_DIV)) >> 3;
      lit       = enable && (pre_d != '0) && (32'(pre_d) < on_cycles);
      sel       = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         sel[k] = lit && (idx_d == IW'(k));
      end
      an_d     = DIGIT_ACTIVE_LOW ? ~sel : sel;
      seg_d    = SEG_ACTIVE_LOW ? ~glyph : glyph;
      dp_pin_d = SEG_ACTIVE_LOW ? ~dp_this : dp_this;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q       <= '0;
         idx_q       <= '0;
         sval_q      <= '0;
         sdp_q       <= '0;
         sblz_q      <= 1'b0;
         primed_q    <= 1'b0;
         seg         <= SEG_OFF;
         dp_out      <= DP_OFF;
         an          <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         idx_q       <= idx_d;
         sval_q      <= sval_d;
         sdp_q       <= sdp_d;
         sblz_q      <= sblz_d;
         primed_q    <= primed_q | enable;
         frame_start <= load;
         an          <= an_d;
         // Segments only change in the dead-time cycle, never under a lit digit.
         if (pre_d == '0) begin
            seg    <= seg_d;
            dp_out <= dp_pin_d;
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        blank_lz;
   logic [2:0]  bright;
   logic [6:0]  seg;
   logic        dp_out;
   logic [3:0]  an;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];

   seven_segment_scanner #(
      .NUM_DIGITS       (4),
      .REFRESH_DIV      (8),
      .SEG_ACTIVE_LOW   (1'b1),
      .DIGIT_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .value       (value),
      .dp          (dp),
      .blank_lz    (blank_lz),
      .bright      (bright),
      .seg         (seg),
      .dp_out      (dp_out),
      .an          (an),
      .frame_start (frame_start)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
      exp_q.push_back(s0);
      exp_q.push_back(s1);
      exp_q.push_back(s2);
      exp_q.push_back(s3);
   endtask

   task automatic wait_fs(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (frame_start !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check(tag, frame_start, 1'b1);
   endtask

   // Called on the negedge where frame_start is high (prescaler 0, digit 0);
   // returns on the negedge of the last cycle of the frame.
   task automatic check_frame(input logic [3:0] exp_dp, input int on);
      logic [6:0] seg_exp [4];
      logic [3:0] an_exp;
      bit         lit;
      for (int d = 0; d < 4; d++) seg_exp[d] = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h00;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 8; c++) begin
            if (d != 0 || c != 0) @(negedge clk);
            lit    = (c >= 1) && (c < on);
            an_exp = lit ? ~(4'b0001 << d) : 4'b1111;
            check("an", an, an_exp);
            check("frame_start", frame_start, (d == 0 && c == 0));
            if (lit) begin
               check("seg", seg, seg_exp[d]);
               check("dp_out", dp_out, !exp_dp[d]);
            end
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      value    = 16'h1234;
      dp       = 4'b0000;
      blank_lz = 1'b0;
      bright   = 3'd7;
      repeat (2) @(negedge clk);
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 7'b1111111);
      check("rst_dp", dp_out, 1'b1);
      check("rst_fs", frame_start, 1'b0);

      // 1: plain scan of 1234
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_fs("fs_first");
      push_frame(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
      check_frame(4'b0000, 8);

      // 2: leading-zero blanking
      value    = 16'h0050;
      blank_lz = 1'b1;
      wait_fs("fs_lz");
      push_frame(7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111);
      check_frame(4'b0000, 8);
      value = 16'h0000;
      wait_fs("fs_zero");
      push_frame(7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
      check_frame(4'b0000, 8);

      // 3: mid-frame change stays hidden until the next frame
      value    = 16'h1111;
      blank_lz = 1'b0;
      wait_fs("fs_ones");
      value = 16'h2222;
      push_frame(7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001);
      check_frame(4'b0000, 8);
      wait_fs("fs_twos");
      push_frame(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);
      check_frame(4'b0000, 8);

      // 4: brightness
      bright = 3'd0;
      wait_fs("fs_b0");
      push_frame(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);
      check_frame(4'b0000, 1);
      bright = 3'd3;
      wait_fs("fs_b3");
      push_frame(7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100);
      check_frame(4'b0000, 4);

      // 5: decimal point on a blanked digit
      bright   = 3'd7;
      value    = 16'h0050;
      blank_lz = 1'b1;
      dp       = 4'b0100;
      wait_fs("fs_dp");
      push_frame(7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111);
      check_frame(4'b0100, 8);

      // 6: enable freeze / resume, then async reset mid-slot
      value    = 16'h1234;
      blank_lz = 1'b0;
      dp       = 4'b0000;
      wait_fs("fs_en");
      repeat (11) @(negedge clk);
      check("en_pre_an", an, 4'b1101);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("en_off_an", an, 4'b1111);
         check("en_off_fs", frame_start, 1'b0);
      end
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("resume_an", an, 4'b1101);
         check("resume_seg", seg, 7'b0110000);
      end
      @(negedge clk);
      check("resume_dead", an, 4'b1111);
      @(negedge clk);
      check("resume_next", an, 4'b1011);
      check("resume_next_seg", seg, 7'b0100100);
      #2 rst_n = 1'b0;
      #1;
      check("arst_an", an, 4'b1111);
      check("arst_seg", seg, 7'b1111111);
      check("arst_dp", dp_out, 1'b1);
      check("arst_fs", frame_start, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_fs("fs_restart");
      push_frame(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
      check_frame(4'b0000, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
